// File: rtl/configregpwm_decode_shadow.sv
// PWM config-word receiver: validates packed words, double-buffers them (pending -> active)
// and applies on a period boundary, or at once when the PWM is stopped or being stopped.
module configregpwm_decode_shadow #(
  parameter int unsigned PWMCOUNT_WIDTH  = 16,
  parameter bit          ALLOW_OVERWRITE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [PWMCOUNT_WIDTH-1:0] wr_data,
  input  logic                      period_evt,
  output logic [1:0]                count_mode,
  output logic                      mask_mode,
  output logic                      dtclkdiv_onoff,
  output logic                      pwmclkdiv_onoff,
  output logic                      int_onoff,
  output logic                      pwm_onoff,
  output logic                      logic_A,
  output logic                      logic_B,
  output logic [PWMCOUNT_WIDTH-1:0] active_word,
  output logic                      pending,
  output logic                      apply_pulse,
  output logic                      cfg_err,
  input  logic                      clr_err
);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t     state, state_next;
  logic [8:0] pend_buf;
  logic [8:0] act;
  logic       accept;
  logic       word_ok;
  logic       apply;

  assign wr_ready = ALLOW_OVERWRITE ? 1'b1 : (state == IDLE);
  assign accept   = wr_valid && wr_ready;
  assign word_ok  = (wr_data[1:0] != 2'b11) && ((wr_data >> 9) == '0);
  assign pending  = (state == ARMED);

  // Stopped PWM (active off) or a forced stop (pending off) bypasses the period wait.
  assign apply = (state == ARMED) && (period_evt || !act[6] || !pend_buf[6]);

  always_comb begin
    state_next = state;
    if (accept && word_ok)
      state_next = ARMED;
    else if (apply)
      state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_buf    <= '0;
      act         <= '0;
      apply_pulse <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      apply_pulse <= apply;
      if (apply)
        act <= pend_buf;
      // A new word accepted on the apply cycle lands in the buffer after the old one moves out.
      if (accept && word_ok)
        pend_buf <= wr_data[8:0];
      if (accept && !word_ok)
        cfg_err <= 1'b1;
      else if (clr_err)
        cfg_err <= 1'b0;
    end
  end

  assign count_mode      = act[1:0];
  assign mask_mode       = act[2];
  assign dtclkdiv_onoff  = act[3];
  assign pwmclkdiv_onoff = act[4];
  assign int_onoff       = act[5];
  assign pwm_onoff       = act[6];
  assign logic_A         = act[7];
  assign logic_B         = act[8];

  always_comb begin
    active_word      = '0;
    active_word[8:0] = act;
  end

endmodule
